// File: rtl/shift_arbiter_pkg.sv
// shift_arbiter_pkg: shared widths and FSM state encoding for the shift arbiter
package shift_arbiter_pkg;
   localparam int DATA_W = 8;
   localparam int AMT_W  = 3;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      RESP  = 2'd2
   } state_e;
endpackage

// File: rtl/shift_core_r8.sv
// shift_core_r8: combinational 8-bit logical right shifter, three log stages with zero fill
//   op_i  - operand
//   amt_i - shift amount 0..7
//   res_o - op_i >> amt_i
module shift_core_r8
   import shift_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] op_i,
   input  logic [AMT_W-1:0]  amt_i,
   output logic [DATA_W-1:0] res_o
);
   logic [DATA_W-1:0] s4, s2;
   always_comb begin
      s4    = amt_i[2] ? {4'b0, op_i[7:4]} : op_i;
      s2    = amt_i[1] ? {2'b0, s4[7:2]}   : s4;
      res_o = amt_i[0] ? {1'b0, s2[7:1]}   : s2;
   end
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one right shifter between NREQ requesters
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_ready   - per-requester handshake (ready one-hot or zero)
//   req_data/req_amt      - packed operands and shift amounts, requester i at slice i
//   rsp_valid/rsp_ready   - response handshake
//   rsp_data/rsp_id       - shifted result and owning requester index
//   busy                  - high whenever the FSM is not idle
module shift_arbiter
   import shift_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int W    = DATA_W,
   parameter int SW   = AMT_W,
   parameter int IDW  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_data,
   input  logic [NREQ*SW-1:0] req_amt,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [W-1:0]      rsp_data,
   output logic [IDW-1:0]    rsp_id,
   output logic              busy
);
   state_e         state_q, state_d;
   logic [IDW-1:0] last_q, last_d, id_q, id_d, rsp_id_q, rsp_id_d;
   logic [W-1:0]   op_q, op_d, rsp_data_q, rsp_data_d, shifted, op_sel;
   logic [SW-1:0]  amt_q, amt_d, amt_sel;
   logic           rsp_valid_q, rsp_valid_d;
   logic           hi_found, lo_found, any;
   logic [IDW-1:0] win_hi, win_lo, win;

   // Round robin: the lowest valid index above last_q wins, otherwise wrap to the lowest valid index.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      win_hi   = '0;
      win_lo   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i] && i > int'(last_q)) begin
            hi_found = 1'b1;
            win_hi   = IDW'(i);
         end
         if (req_valid[i] && i <= int'(last_q)) begin
            lo_found = 1'b1;
            win_lo   = IDW'(i);
         end
      end
      win     = hi_found ? win_hi : win_lo;
      any     = hi_found | lo_found;
      op_sel  = '0;
      amt_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == IDW'(i)) begin
            op_sel  = req_data[i*W +: W];
            amt_sel = req_amt[i*SW +: SW];
         end
      end
   end

   shift_core_r8 u_core (
      .op_i  (op_q),
      .amt_i (amt_q),
      .res_o (shifted)
   );

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      op_d        = op_q;
      amt_d       = amt_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      case (state_q)
         IDLE: if (any) begin
            state_d = SHIFT;
            last_d  = win;
            op_d    = op_sel;
            amt_d   = amt_sel;
            id_d    = win;
         end
         SHIFT: begin
            state_d     = RESP;
            rsp_data_d  = shifted;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
         end
         RESP: if (rsp_ready) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
         end
         // The unused encoding falls back to idle without emitting a response.
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= IDW'(NREQ - 1);
         op_q        <= '0;
         amt_q       <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         op_q        <= op_d;
         amt_q       <= amt_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   assign req_ready = (state_q == IDLE && any) ? NREQ'(1) << win : '0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: randomized and directed checks of shift_arbiter against a transaction-level model
module tb_shift_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [15:0] req_data = '0;
   logic [5:0]  req_amt = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [7:0]  rsp_data;
   logic [0:0]  rsp_id;
   logic        busy;

   int n_checks = 0;
   int n_fail = 0;

   // Model: one transaction in flight, aged in cycles since acceptance.
   bit         m_busy = 0;
   int         m_age = 0;
   int         m_last = 1;
   logic [7:0] m_pend_data = '0;
   logic [7:0] m_rsp_data = '0;
   int         m_pend_id = 0;
   int         m_rsp_id = 0;
   int         grants_id1 = 0;

   shift_arbiter #(.NREQ(2), .W(8), .SW(3), .IDW(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_amt   (req_amt),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic [1:0] v, input logic [7:0] d0, input logic [2:0] a0,
                       input logic [7:0] d1, input logic [2:0] a1, input logic rr);
      int w;
      logic [7:0] op;
      logic [2:0] amt;
      @(negedge clk);
      req_valid = v;
      req_data  = {d1, d0};
      req_amt   = {a1, a0};
      rsp_ready = rr;
      #1;
      w = -1;
      for (int k = 1; k <= 2; k++) begin
         int idx;
         idx = (m_last + k) % 2;
         if (w < 0 && v[idx]) w = idx;
      end
      check("req_ready", 32'(req_ready), (!m_busy && w >= 0) ? 32'(1) << w : 32'd0);
      check("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 1));
      check("busy", 32'(busy), 32'(m_busy));
      check("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
      check("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
      if (!m_busy) begin
         if (w >= 0) begin
            op          = (w == 0) ? d0 : d1;
            amt         = (w == 0) ? a0 : a1;
            m_busy      = 1;
            m_age       = 0;
            m_pend_data = op >> amt;
            m_pend_id   = w;
            m_last      = w;
            if (w == 1) grants_id1++;
         end
      end else if (m_age == 0) begin
         m_age      = 1;
         m_rsp_data = m_pend_data;
         m_rsp_id   = m_pend_id;
      end else if (rr) begin
         m_busy = 0;
      end
   endtask

   task automatic idle_cycles(input int n, input logic rr);
      for (int i = 0; i < n; i++) step(2'b00, 8'h00, 3'd0, 8'h00, 3'd0, rr);
   endtask

   task automatic amt_case(input logic [2:0] a, input logic [7:0] exp);
      step(2'b01, 8'hA5, a, 8'h00, 3'd0, 1'b1);
      step(2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 1'b1);
      step(2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 1'b1);
      check("amt_boundary", 32'(rsp_data), 32'(exp));
   endtask

   initial begin
      int g1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single request, response after two edges
      step(2'b01, 8'hB4, 3'd3, 8'h00, 3'd0, 1'b1);
      step(2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 1'b1);
      step(2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 1'b1);
      check("plan_b4_data", 32'(rsp_data), 32'h16);
      check("plan_b4_valid", 32'(rsp_valid), 32'd1);
      idle_cycles(2, 1'b1);

      // Both valid: grants alternate
      for (int i = 0; i < 12; i++) step(2'b11, 8'hFF, 3'd1, 8'h80, 3'd7, 1'b1);

      // Backpressure for several cycles then release
      step(2'b01, 8'h3C, 3'd2, 8'h00, 3'd0, 1'b0);
      idle_cycles(7, 1'b0);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_data", 32'(rsp_data), 32'h0F);
      idle_cycles(3, 1'b1);

      // Boundary shift amounts
      amt_case(3'd0, 8'hA5);
      amt_case(3'd7, 8'h01);
      amt_case(3'd4, 8'h0A);

      // req1 valid only briefly while the FSM is in RESP
      g1 = grants_id1;
      step(2'b01, 8'h11, 3'd0, 8'h00, 3'd0, 1'b0);
      step(2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 1'b0);
      step(2'b10, 8'h00, 3'd0, 8'h22, 3'd0, 1'b0);
      step(2'b00, 8'h00, 3'd0, 8'h00, 3'd0, 1'b1);
      idle_cycles(3, 1'b1);
      check("withdrawn_id1_grants", 32'(grants_id1), 32'(g1));
      check("withdrawn_rsp_id", 32'(rsp_id), 32'd0);

      // Reset while in SHIFT
      step(2'b10, 8'h00, 3'd0, 8'hF0, 3'd4, 1'b1);
      @(negedge clk);
      req_valid = 2'b00;
      rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      m_busy = 0; m_age = 0; m_last = 1; m_rsp_data = '0; m_rsp_id = 0;
      @(negedge clk);
      rst_n = 1'b1;
      step(2'b11, 8'h40, 3'd1, 8'h40, 3'd2, 1'b1);
      check("midrst_first_grant", 32'(rsp_valid), 32'd0);
      idle_cycles(3, 1'b1);
      check("midrst_rsp_id", 32'(rsp_id), 32'd0);
      check("midrst_rsp_data", 32'(rsp_data), 32'h20);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         step(2'($urandom), 8'($urandom), 3'($urandom), 8'($urandom), 3'($urandom),
              $urandom_range(0, 3) != 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
